// File: rtl/ddr3_mon_pkg.sv
// Shared definitions for the DDR3 command-bus monitor: command encodings,
// init-sequence states, error codes and the pin-level command decode.
package ddr3_mon_pkg;

    // {ras_n, cas_n, we_n} as driven on the pins.
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        WAIT_MR2,
        WAIT_MR3,
        WAIT_MR1,
        WAIT_MR0,
        WAIT_ZQ,
        INIT_DONE
    } init_state_e;

    localparam logic [3:0] ERR_NONE        = 4'd0;
    localparam logic [3:0] ERR_PREINIT     = 4'd1;
    localparam logic [3:0] ERR_MRS_ORDER   = 4'd2;
    localparam logic [3:0] ERR_ACT_OPEN    = 4'd3;
    localparam logic [3:0] ERR_ACT_RP      = 4'd4;
    localparam logic [3:0] ERR_RDWR_CLOSED = 4'd5;
    localparam logic [3:0] ERR_RDWR_RCD    = 4'd6;
    localparam logic [3:0] ERR_PRE_RAS     = 4'd7;
    localparam logic [3:0] ERR_REF_OPEN    = 4'd8;
    localparam logic [3:0] ERR_MRS_OPEN    = 4'd9;
    localparam logic [3:0] ERR_BUSY        = 4'd10;

    // One sampled command: only the bank and A10 matter to the checks.
    typedef struct packed {
        cmd_e       cmd;
        logic [2:0] ba;
        logic       a10;
    } pin_cmd_t;

    // Deselect (cs_n=1) or clock-disabled (cke=0) cycles are NOPs.
    function automatic cmd_e decode_cmd(input logic cke, input logic csn,
                                        input logic rasn, input logic casn,
                                        input logic wen);
        if (cke && !csn) return cmd_e'({rasn, casn, wen});
        return CMD_NOP;
    endfunction

    // Mode register the init sequence expects next (MR2, MR3, MR1, MR0).
    function automatic logic [2:0] expected_mr(input init_state_e s);
        case (s)
            WAIT_MR2: return 3'd2;
            WAIT_MR3: return 3'd3;
            WAIT_MR1: return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ddr3_mon_bank.sv
// Per-bank timing tracker: open flag, tRCD/tRP down-counters and a
// saturating cycles-since-ACT counter for tRAS. Emits error strobes for
// the command presented this cycle; the top resolves priority.
module ddr3_mon_bank #(
    parameter int T_RCD = 6,
    parameter int T_RP  = 6,
    parameter int T_RAS = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic act_i,
    input  logic rdwr_i,
    input  logic ap_i,
    input  logic pre_i,
    output logic open_o,
    output logic err_act_open_o,
    output logic err_act_rp_o,
    output logic err_rdwr_closed_o,
    output logic err_rdwr_rcd_o,
    output logic err_pre_ras_o
);

    localparam int RCD_W = $clog2(T_RCD + 1);
    localparam int RP_W  = $clog2(T_RP + 1);
    localparam int RAS_W = $clog2(T_RAS + 1);

    logic             open_q;
    logic [RCD_W-1:0] rcd_q;
    logic [RP_W-1:0]  rp_q;
    logic [RAS_W-1:0] ras_q;

    // Bank state: counters free-run toward their limits, commands reload them.
    // ras_q is loaded with 1 on ACT so that on the cycle a PRE arrives k
    // cycles after the ACT it reads k; a PRE is legal once it reads T_RAS.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            open_q <= 1'b0;
            rcd_q  <= '0;
            rp_q   <= '0;
            ras_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let the later command-driven loads
            // below override these default count updates within the same edge.
            if (rcd_q != '0) rcd_q <= rcd_q - 1'b1;
            if (rp_q != '0) rp_q <= rp_q - 1'b1;
            if (ras_q != RAS_W'(T_RAS)) ras_q <= ras_q + 1'b1;

            if (act_i) begin
                open_q <= 1'b1;
                rcd_q  <= RCD_W'(T_RCD - 1);
                ras_q  <= RAS_W'(1);
            end else if ((rdwr_i && ap_i && open_q) || (pre_i && open_q)) begin
                open_q <= 1'b0;
                rp_q   <= RP_W'(T_RP - 1);
            end
        end
    end

    assign open_o            = open_q;
    assign err_act_open_o    = act_i && open_q;
    assign err_act_rp_o      = act_i && (rp_q != '0);
    assign err_rdwr_closed_o = rdwr_i && !open_q;
    assign err_rdwr_rcd_o    = rdwr_i && (rcd_q != '0);
    // Auto-precharge on RD/WR is deliberately exempt from the tRAS check.
    assign err_pre_ras_o     = pre_i && open_q && (ras_q < RAS_W'(T_RAS));

endmodule

// File: rtl/ddr3_cmd_monitor.sv
// DDR3 command-bus monitor: registers the command pins once, decodes the
// command, tracks the MRS/ZQCL init sequence and per-bank state, latches
// the first protocol violation and counts ACT/RD/WR/REF commands.
module ddr3_cmd_monitor
    import ddr3_mon_pkg::*;
#(
    parameter int T_RCD = 6,
    parameter int T_RP  = 6,
    parameter int T_RAS = 15,
    parameter int T_RFC = 64,
    parameter int T_MRD = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pad_rstn_ch0,
    input  logic             pad_cke_ch0,
    input  logic             pad_csn_ch0,
    input  logic             pad_rasn_ch0,
    input  logic             pad_casn_ch0,
    input  logic             pad_wen_ch0,
    input  logic [2:0]       pad_ba_ch0,
    input  logic [15:0]      pad_addr_ch0,
    output logic             init_seen,
    output logic [7:0]       bank_open,
    output logic             err_flag,
    output logic [3:0]       err_code,
    output logic [CNT_W-1:0] act_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] ref_cnt
);

    localparam int T_BUSY = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int BUSY_W = $clog2(T_BUSY + 1);

    // Either reset source clears everything; both are sampled on the clock.
    logic sync_rst_n;
    assign sync_rst_n = resetn && pad_rstn_ch0;

    // Row/column bits are not checked by this monitor.
    logic unused_addr;
    assign unused_addr = ^{pad_addr_ch0[15:11], pad_addr_ch0[9:0]};

    pin_cmd_t          pin_q;
    init_state_e       init_q;
    logic              init_seen_q;
    logic [BUSY_W-1:0] busy_q;
    logic              err_flag_q;
    logic [3:0]        err_code_q;
    logic [CNT_W-1:0]  act_cnt_q, rd_cnt_q, wr_cnt_q, ref_cnt_q;

    // Pin capture stage: one register between the pads and all decode logic.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            pin_q <= '{cmd: CMD_NOP, ba: 3'd0, a10: 1'b0};
        end else begin
            pin_q <= '{cmd: decode_cmd(pad_cke_ch0, pad_csn_ch0, pad_rasn_ch0,
                                       pad_casn_ch0, pad_wen_ch0),
                       ba: pad_ba_ch0, a10: pad_addr_ch0[10]};
        end
    end

    logic is_mrs, is_ref, is_pre, is_act, is_rd, is_wr, is_zq, is_nop;
    logic init_done, mrs_in_order;
    logic [7:0] ba_oh;

    assign is_mrs    = (pin_q.cmd == CMD_MRS);
    assign is_ref    = (pin_q.cmd == CMD_REF);
    assign is_pre    = (pin_q.cmd == CMD_PRE);
    assign is_act    = (pin_q.cmd == CMD_ACT);
    assign is_rd     = (pin_q.cmd == CMD_RD);
    assign is_wr     = (pin_q.cmd == CMD_WR);
    assign is_zq     = (pin_q.cmd == CMD_ZQ);
    assign is_nop    = (pin_q.cmd == CMD_NOP);
    assign ba_oh     = 8'd1 << pin_q.ba;
    assign init_done = (init_q == INIT_DONE);
    assign mrs_in_order = is_mrs && (init_q inside {WAIT_MR2, WAIT_MR3, WAIT_MR1, WAIT_MR0})
                          && (pin_q.ba == expected_mr(init_q));

    logic [7:0] open_b, e_act_open, e_act_rp, e_rdwr_closed, e_rdwr_rcd, e_pre_ras;

    for (genvar b = 0; b < 8; b++) begin : g_bank
        ddr3_mon_bank #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS)) u_bank (
            .clk_i             (clk),
            .rst_n_i           (sync_rst_n),
            .act_i             (is_act && ba_oh[b]),
            .rdwr_i            ((is_rd || is_wr) && ba_oh[b]),
            .ap_i              (pin_q.a10),
            .pre_i             (is_pre && (pin_q.a10 || ba_oh[b])),
            .open_o            (open_b[b]),
            .err_act_open_o    (e_act_open[b]),
            .err_act_rp_o      (e_act_rp[b]),
            .err_rdwr_closed_o (e_rdwr_closed[b]),
            .err_rdwr_rcd_o    (e_rdwr_rcd[b]),
            .err_pre_ras_o     (e_pre_ras[b])
        );
    end

    logic [10:1] err_vec;
    logic [3:0]  err_now;

    // Collect this cycle's violations and keep the lowest-numbered one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch.
        err_vec = '0;
        err_now = ERR_NONE;
        err_vec[ERR_PREINIT]     = !init_done && !(is_mrs || is_zq || is_nop);
        err_vec[ERR_MRS_ORDER]   = !init_done && is_mrs && !mrs_in_order;
        err_vec[ERR_ACT_OPEN]    = |e_act_open;
        err_vec[ERR_ACT_RP]      = |e_act_rp;
        err_vec[ERR_RDWR_CLOSED] = |e_rdwr_closed;
        err_vec[ERR_RDWR_RCD]    = |e_rdwr_rcd;
        err_vec[ERR_PRE_RAS]     = |e_pre_ras;
        err_vec[ERR_REF_OPEN]    = is_ref && (|open_b);
        err_vec[ERR_MRS_OPEN]    = is_mrs && init_done && (|open_b);
        err_vec[ERR_BUSY]        = !is_nop && (busy_q != '0);
        for (int i = 10; i >= 1; i--) begin
            if (err_vec[i]) err_now = 4'(i);
        end
    end

    // Init sequence FSM: MR2, MR3, MR1, MR0 in order, then ZQCL.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            init_q      <= WAIT_MR2;
            init_seen_q <= 1'b0;
        end else begin
            case (init_q)
                WAIT_MR2: if (mrs_in_order) init_q <= WAIT_MR3;
                WAIT_MR3: if (mrs_in_order) init_q <= WAIT_MR1;
                WAIT_MR1: if (mrs_in_order) init_q <= WAIT_MR0;
                WAIT_MR0: if (mrs_in_order) init_q <= WAIT_ZQ;
                WAIT_ZQ: begin
                    if (is_zq && pin_q.a10) begin
                        init_q      <= INIT_DONE;
                        init_seen_q <= 1'b1;
                    end
                end
                default: init_q <= INIT_DONE;
            endcase
        end
    end

    // Global busy window, sticky first-error capture and command counters.
    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            busy_q     <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= ERR_NONE;
            act_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            ref_cnt_q  <= '0;
        end else begin
            if (is_ref)              busy_q <= BUSY_W'(T_RFC - 1);
            else if (is_mrs)         busy_q <= BUSY_W'(T_MRD - 1);
            else if (busy_q != '0)   busy_q <= busy_q - 1'b1;

            if (!err_flag_q && (err_now != ERR_NONE)) begin
                err_flag_q <= 1'b1;
                err_code_q <= err_now;
            end

            if (is_act) act_cnt_q <= act_cnt_q + 1'b1;
            if (is_rd)  rd_cnt_q  <= rd_cnt_q + 1'b1;
            if (is_wr)  wr_cnt_q  <= wr_cnt_q + 1'b1;
            if (is_ref) ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    assign init_seen = init_seen_q;
    assign bank_open = open_b;
    assign err_flag  = err_flag_q;
    assign err_code  = err_code_q;
    assign act_cnt   = act_cnt_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign ref_cnt   = ref_cnt_q;

endmodule

// File: doc/ddr3_cmd_monitor.md
# ddr3_cmd_monitor

Synthesizable DDR3 command-bus monitor that sits on the memory-device end of the hmemc pad interface, in parallel with the DDR3 model in simulation or on the pins in hardware bring-up. It decodes every command the controller issues and tracks the MRS/ZQCL init sequence and per-bank open/closed state. It checks minimum command spacing in DDR clock cycles and reports the first protocol violation plus running command counts.

## Interface
Parameters:
- T_RCD, 6, min cycles ACT→RD/WR same bank
- T_RP, 6, min cycles PRE→ACT same bank
- T_RAS, 15, min cycles ACT→PRE same bank
- T_RFC, 64, min cycles REF→any non-NOP command
- T_MRD, 4, min cycles MRS→any non-NOP command
- CNT_W, 16, width of command counters

Ports:
- clk  in  1  DDR clock (pad_ddr_clk_w domain)
- resetn  in  1  synchronous, active-low reset
- pad_rstn_ch0  in  1  DRAM reset pin; low behaves like resetn
- pad_cke_ch0, pad_csn_ch0, pad_rasn_ch0, pad_casn_ch0, pad_wen_ch0  in  1 each  command pins
- pad_ba_ch0  in  3  bank address
- pad_addr_ch0  in  16  address; A10 = all-bank / auto-precharge
- init_seen  out  1  MR2,MR3,MR1,MR0,ZQCL observed in order
- bank_open  out  8  per-bank row-open flags
- err_flag  out  1  sticky error
- err_code  out  4  code of first error
- act_cnt, rd_cnt, wr_cnt, ref_cnt  out  CNT_W each  wrapping command counters

## Operation
- Command valid when cke=1 and cs_n=0; {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 110 ZQ, 111 NOP. cs_n=1 or cke=0 → NOP.
- Init FSM: WAIT_MR2 → WAIT_MR3 → WAIT_MR1 → WAIT_MR0 → WAIT_ZQ → DONE. MRS advances only if BA equals expected MR number; ZQ with A10=1 (ZQCL) finishes. Any non-MRS/ZQ/NOP before DONE → err 1; MRS with wrong BA → err 2. DONE sets init_seen.
- Per bank b: open flag, row_since_act counter (saturating at T_RAS), rcd/rp down-counters.
- ACT: bank open → err 3; rp counter nonzero → err 4; else open, load rcd=T_RCD-1, reset ras count.
- RD/WR: bank closed → err 5; rcd nonzero → err 6. A10=1 → auto-precharge: close bank, load rp=T_RP-1 (tRAS not checked on auto-PRE).
- PRE: A10=1 all banks, else BA bank. Each open target bank with ras count < T_RAS → err 7; closes, loads rp. PRE to closed bank is legal (no reload).
- REF: any bank open → err 8; loads global busy=T_RFC-1.
- MRS after init: any bank open → err 9; loads busy=T_MRD-1.
- Any non-NOP while busy≠0 → err 10.
- One error per cycle; priority = lowest code. Only first error latched into err_code; err_flag stays high until reset. State still updates per command despite errors.
- Counters increment on each decoded ACT/RD/WR/REF (auto-precharge RD/WR count as RD/WR), wrap at 2^CNT_W.

## Timing
- Pins registered once; decoded state/outputs update on the edge after the pin-sample edge (latency 2 cycles pin→output).
- Down-counters decrement every cycle to 0; command legal on the cycle the counter reads 0, i.e. exactly T_x cycles after the earlier command.
- Reset (resetn=0 or pad_rstn_ch0=0 sampled at clk edge): all outputs 0, FSM WAIT_MR2, all banks closed, all counters 0. Reset mid-sequence discards all state.

## Structure
- Package ddr3_mon_pkg: command encodings, init-state enum, err_code constants 1–10.
- Sub-module ddr3_mon_bank (one per bank, generate ×8): open flag, rcd/rp/ras counters, emits per-bank error strobes.

## Test plan
- MRS BA=2,3,1,0 at T_MRD spacing, ZQ A10=1 → init_seen=1, err_flag=0.
- Init then ACT bank 3 row 0x100, RD bank 3 after 6 cycles, PRE after 15 → act_cnt=1, rd_cnt=1, bank_open=0, no error.
- ACT bank 0, RD bank 0 after 5 cycles → err_flag=1, err_code=6.
- ACT bank 1, then REF while open, then RD closed bank 2 → err_code stays 8, rd_cnt=1.
- Before init, issue ACT → err_code=1; assert resetn low for 1 cycle → all outputs 0.
- WR bank 5 A10=1 after valid ACT, ACT bank 5 after 5 cycles → err_code=4; ACT after 6 → legal in clean rerun.
